// File: rtl/end_screen_pkg.sv
// Shared definitions for the end-screen controller: FSM states, pixel-source
// select codes, blanking colour and the restart-box rectangle/border tests.
package end_screen_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHOW,
      ARMED,
      FIRE,
      WAIT_REL
   } state_t;

   typedef enum logic [1:0] {
      SEL_BLANK,
      SEL_BG,
      SEL_HILITE,
      SEL_PIXEL
   } rgb_sel_t;

   localparam logic [11:0] BLANK_RGB = 12'h000;
   localparam logic [11:0] BORDER_T  = 12'd2;

   // Half-open rectangle: left/top edges inclusive, right/bottom exclusive.
   function automatic logic in_rect(input logic [11:0] x,  input logic [11:0] y,
                                    input logic [11:0] x0, input logic [11:0] x1,
                                    input logic [11:0] y0, input logic [11:0] y1);
      return (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
   endfunction

   function automatic logic on_border(input logic [11:0] x,  input logic [11:0] y,
                                      input logic [11:0] x0, input logic [11:0] x1,
                                      input logic [11:0] y0, input logic [11:0] y1);
      return in_rect(x, y, x0, x1, y0, y1) &&
             ((x < x0 + BORDER_T) || (x >= x1 - BORDER_T) ||
              (y < y0 + BORDER_T) || (y >= y1 - BORDER_T));
   endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth register pipe used to keep VGA timing signals aligned with the
// pixel pipeline. Synchronous active-low reset clears every stage.
module vga_delay #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 26
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/end_screen_ctrl.sv
// End-of-game screen: scaled image overlay, blinking restart box and restart pulse.
// Define END_SCREEN_BEST_SCORE_EN to track the best score across games.
module end_screen_ctrl
   import end_screen_pkg::*;
#(
   parameter int          IMG_X        = 160,
   parameter int          IMG_Y        = 114,
   parameter int          IMG_XW       = 8,
   parameter int          IMG_YW       = 7,
   parameter int          SCALE_LOG2   = 1,
   parameter int          BOX_X        = 306,
   parameter int          BOX_Y        = 294,
   parameter int          BOX_W        = 150,
   parameter int          BOX_H        = 58,
   parameter logic [11:0] BG_RGB       = 12'h0a0,
   parameter logic [11:0] HILITE_RGB   = 12'hff0,
   parameter int          BLINK_FRAMES = 15,
   parameter int          SCORE_W      = 10
) (
   input  logic                     clk40,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     left,
   input  logic [10:0]              hcount,
   input  logic [10:0]              vcount,
   input  logic                     hsync,
   input  logic                     vsync,
   input  logic                     hblnk,
   input  logic                     vblnk,
   input  logic [11:0]              xpos,
   input  logic [11:0]              ypos,
   input  logic [SCORE_W-1:0]       result_in,
   input  logic [11:0]              rgb_pixel,
   output logic [IMG_YW+IMG_XW-1:0] pixel_addr,
   output logic [10:0]              hcount_out,
   output logic [10:0]              vcount_out,
   output logic                     hs,
   output logic                     vs,
   output logic                     hblnk_out,
   output logic                     vblnk_out,
   output logic [11:0]              rgb_out,
   output logic                     restart,
   output logic [SCORE_W-1:0]       score_out,
   output logic [SCORE_W-1:0]       best_out,
   output state_t                   state_dbg
);

   localparam logic [11:0] IMG_X0 = 12'(IMG_X);
   localparam logic [11:0] IMG_X1 = 12'(IMG_X + ((1 << IMG_XW) << SCALE_LOG2));
   localparam logic [11:0] IMG_Y0 = 12'(IMG_Y);
   localparam logic [11:0] IMG_Y1 = 12'(IMG_Y + ((1 << IMG_YW) << SCALE_LOG2));
   localparam logic [11:0] BOX_X0 = 12'(BOX_X);
   localparam logic [11:0] BOX_X1 = 12'(BOX_X + BOX_W);
   localparam logic [11:0] BOX_Y0 = 12'(BOX_Y);
   localparam logic [11:0] BOX_Y1 = 12'(BOX_Y + BOX_H);
   localparam int          BLINK_CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_FRAMES - 1);

   state_t                     state_q, state_d;
   rgb_sel_t                   sel1_q, sel2_q, sel_d;
   logic [IMG_YW+IMG_XW-1:0]   pixel_addr_q, pixel_addr_d;
   logic [BLINK_CW-1:0]        blink_cnt_q, blink_cnt_d;
   logic                       phase_q, phase_d;
   logic                       enable_q, left_q, vsync_q;
   logic [SCORE_W-1:0]         score_q;
   logic [11:0]                hc12, vc12, x_off, y_off;
   logic                       enable_rise, left_rise, vsync_rise;
   logic                       cursor_in_box, in_img, hilite, show_entry;

   vga_delay #(.DEPTH(2), .WIDTH(26)) u_timing_dly (
      .clk_i  (clk40),
      .rst_ni (rst),
      .din_i  ({hcount, vcount, hsync, vsync, hblnk, vblnk}),
      .dout_o ({hcount_out, vcount_out, hs, vs, hblnk_out, vblnk_out})
   );

   assign hc12          = {1'b0, hcount};
   assign vc12          = {1'b0, vcount};
   assign x_off         = hc12 - IMG_X0;
   assign y_off         = vc12 - IMG_Y0;
   assign pixel_addr_d  = {IMG_YW'(y_off >> SCALE_LOG2), IMG_XW'(x_off >> SCALE_LOG2)};
   assign enable_rise   = enable & ~enable_q;
   assign left_rise     = left & ~left_q;
   assign vsync_rise    = vsync & ~vsync_q;
   assign cursor_in_box = in_rect(xpos, ypos, BOX_X0, BOX_X1, BOX_Y0, BOX_Y1);
   assign in_img        = in_rect(hc12, vc12, IMG_X0, IMG_X1, IMG_Y0, IMG_Y1);
   assign hilite        = (state_q == ARMED) && phase_q && cursor_in_box &&
                          on_border(hc12, vc12, BOX_X0, BOX_X1, BOX_Y0, BOX_Y1);
   assign show_entry    = (state_q == IDLE) && enable_rise;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (enable_rise) state_d = SHOW;
         SHOW:     if (!enable) state_d = IDLE;
                   else if (!left) state_d = ARMED;
         ARMED:    if (!enable) state_d = IDLE;
                   else if (left_rise && cursor_in_box) state_d = FIRE;
         FIRE:     state_d = WAIT_REL;
         WAIT_REL: if (!left && !enable) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Blink phase restarts "on" every time the box becomes clickable.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if ((state_d == ARMED) && (state_q != ARMED)) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (state_q != ARMED) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (vsync_rise) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      sel_d = SEL_BG;
      if (hblnk || vblnk) sel_d = SEL_BLANK;
      else if (!enable)   sel_d = SEL_BG;
      else if (hilite)    sel_d = SEL_HILITE;
      else if (in_img)    sel_d = SEL_PIXEL;
   end

   always_ff @(posedge clk40) begin
      if (!rst) begin
         state_q      <= IDLE;
         sel1_q       <= SEL_BLANK;
         sel2_q       <= SEL_BLANK;
         pixel_addr_q <= '0;
         blink_cnt_q  <= '0;
         phase_q      <= 1'b0;
         enable_q     <= 1'b0;
         left_q       <= 1'b0;
         vsync_q      <= 1'b0;
         score_q      <= '0;
      end else begin
         state_q      <= state_d;
         sel1_q       <= sel_d;
         sel2_q       <= sel1_q;
         pixel_addr_q <= pixel_addr_d;
         blink_cnt_q  <= blink_cnt_d;
         phase_q      <= phase_d;
         enable_q     <= enable;
         left_q       <= left;
         vsync_q      <= vsync;
         if (show_entry) score_q <= result_in;
      end
   end

`ifdef END_SCREEN_BEST_SCORE_EN
   logic [SCORE_W-1:0] best_q;

   always_ff @(posedge clk40) begin
      if (!rst) best_q <= '0;
      else if (show_entry && (result_in > best_q)) best_q <= result_in;
   end

   assign best_out = best_q;
`else
   assign best_out = '0;
`endif

   // ROM data arrives in the same cycle as the delayed timing, so it is muxed in unregistered.
   always_comb begin
      case (sel2_q)
         SEL_BG:     rgb_out = BG_RGB;
         SEL_HILITE: rgb_out = HILITE_RGB;
         SEL_PIXEL:  rgb_out = rgb_pixel;
         default:    rgb_out = BLANK_RGB;
      endcase
   end

   // Gated with rst so a reset landing in FIRE never emits the pulse.
   assign restart    = (state_q == FIRE) && rst;
   assign pixel_addr = pixel_addr_q;
   assign score_out  = score_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Directed self-checking bench for end_screen_ctrl: pipeline, window, FSM,
// restart box bounds, blink highlight, best score and reset behaviour.
module tb_end_screen_ctrl;
   import end_screen_pkg::*;

   localparam logic [11:0] BG  = 12'h0a0;
   localparam logic [11:0] HI  = 12'hff0;
   localparam logic [11:0] PIX = 12'h5a5;

   logic        clk40 = 1'b0;
   logic        rst, enable, left, hsync, vsync, hblnk, vblnk;
   logic [10:0] hcount, vcount;
   logic [11:0] xpos, ypos, rgb_pixel;
   logic [9:0]  result_in;
   logic [14:0] pixel_addr;
   logic [10:0] hcount_out, vcount_out;
   logic        hs, vs, hblnk_out, vblnk_out, restart;
   logic [11:0] rgb_out;
   logic [9:0]  score_out, best_out;
   state_t      state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [9:0] exp_q[$];

   end_screen_ctrl dut (
      .clk40(clk40), .rst(rst), .enable(enable), .left(left),
      .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
      .hblnk(hblnk), .vblnk(vblnk), .xpos(xpos), .ypos(ypos),
      .result_in(result_in), .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .hs(hs), .vs(vs),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out),
      .restart(restart), .score_out(score_out), .best_out(best_out),
      .state_dbg(state_dbg)
   );

   always #12 clk40 = ~clk40;

   task automatic step();
      @(posedge clk40);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; enable = 1'b0; left = 1'b0;
      hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0; hblnk = 1'b0; vblnk = 1'b0;
      xpos = '0; ypos = '0; result_in = '0; rgb_pixel = PIX;
      step(); step();
      rst = 1'b1;
   endtask

   task automatic go_armed(input logic [9:0] score);
      do_reset();
      result_in = score; enable = 1'b1; left = 1'b1;
      step();
      left = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      hcount = 11'd200; vcount = 11'd150; hsync = 1'b1; vsync = 1'b1;
      enable = 1'b1; left = 1'b1; result_in = 10'd37;
      rst = 1'b0;
      step(); step();
      n_checks++; if (state_dbg !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
      n_checks++; if (restart !== 1'b0) begin n_errors++; $display("FAIL reset_restart: got %b want 0", restart); end
      n_checks++; if (score_out !== 10'd0) begin n_errors++; $display("FAIL reset_score: got %0d want 0", score_out); end
      n_checks++; if (best_out !== 10'd0) begin n_errors++; $display("FAIL reset_best: got %0d want 0", best_out); end
      n_checks++; if (pixel_addr !== 15'd0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", pixel_addr); end
      n_checks++; if (rgb_out !== 12'h000) begin n_errors++; $display("FAIL reset_rgb: got %h want 000", rgb_out); end
      n_checks++; if ({hcount_out, vcount_out, hs, vs, hblnk_out, vblnk_out} !== 26'd0) begin
         n_errors++; $display("FAIL reset_timing: got h=%0d v=%0d hs=%b vs=%b want all 0", hcount_out, vcount_out, hs, vs);
      end
      rst = 1'b1;
   endtask

   task automatic test_pipeline();
      do_reset();
      hcount = 11'd200; vcount = 11'd150; hsync = 1'b1; enable = 1'b1; left = 1'b1;
      step();
      n_checks++; if (pixel_addr !== {7'd18, 8'd20}) begin n_errors++; $display("FAIL pipe_addr: got %h want %h", pixel_addr, {7'd18, 8'd20}); end
      n_checks++; if (hcount_out !== 11'd0) begin n_errors++; $display("FAIL pipe_h_lat1: got %0d want 0", hcount_out); end
      step();
      n_checks++; if (hcount_out !== 11'd200 || vcount_out !== 11'd150 || hs !== 1'b1) begin
         n_errors++; $display("FAIL pipe_timing: got h=%0d v=%0d hs=%b want 200 150 1", hcount_out, vcount_out, hs);
      end
      n_checks++; if (rgb_out !== PIX) begin n_errors++; $display("FAIL pipe_rgb: got %h want %h", rgb_out, PIX); end
   endtask

   task automatic test_window();
      logic [10:0] hv [8][2];
      logic [11:0] ev [8];
      hv = '{'{11'd159, 11'd150}, '{11'd160, 11'd150}, '{11'd671, 11'd150}, '{11'd672, 11'd150},
             '{11'd200, 11'd113}, '{11'd200, 11'd114}, '{11'd200, 11'd369}, '{11'd200, 11'd370}};
      ev = '{BG, PIX, PIX, BG, BG, PIX, PIX, BG};
      do_reset();
      enable = 1'b1; left = 1'b1;
      for (int i = 0; i < 8; i++) begin
         hcount = hv[i][0]; vcount = hv[i][1];
         step(); step();
         n_checks++; if (rgb_out !== ev[i]) begin n_errors++; $display("FAIL window_%0d_%0d: got %h want %h", hcount, vcount, rgb_out, ev[i]); end
      end
      hcount = 11'd200; vcount = 11'd150; hblnk = 1'b1;
      step(); step();
      n_checks++; if (rgb_out !== 12'h000) begin n_errors++; $display("FAIL window_blank: got %h want 000", rgb_out); end
      hblnk = 1'b0; enable = 1'b0;
      step(); step();
      n_checks++; if (rgb_out !== BG) begin n_errors++; $display("FAIL window_disabled: got %h want %h", rgb_out, BG); end
   endtask

   task automatic test_carried_press();
      do_reset();
      result_in = 10'd37; enable = 1'b1; left = 1'b1; xpos = 12'd310; ypos = 12'd300;
      step();
      n_checks++; if (score_out !== 10'd37) begin n_errors++; $display("FAIL carry_score: got %0d want 37", score_out); end
      n_checks++; if (state_dbg !== SHOW) begin n_errors++; $display("FAIL carry_show: got %0d want %0d", state_dbg, SHOW); end
      step();
      n_checks++; if (state_dbg !== SHOW || restart !== 1'b0) begin n_errors++; $display("FAIL carry_hold: got state %0d restart %b want %0d 0", state_dbg, restart, SHOW); end
      left = 1'b0;
      step();
      n_checks++; if (state_dbg !== ARMED || restart !== 1'b0) begin n_errors++; $display("FAIL carry_armed: got state %0d restart %b want %0d 0", state_dbg, restart, ARMED); end
   endtask

   task automatic test_click_in_box();
      go_armed(10'd5);
      xpos = 12'd310; ypos = 12'd300; left = 1'b1;
      step();
      n_checks++; if (restart !== 1'b1 || state_dbg !== FIRE) begin n_errors++; $display("FAIL click_fire: got restart %b state %0d want 1 %0d", restart, state_dbg, FIRE); end
      step();
      n_checks++; if (restart !== 1'b0 || state_dbg !== WAIT_REL) begin n_errors++; $display("FAIL click_one_cycle: got restart %b state %0d want 0 %0d", restart, state_dbg, WAIT_REL); end
      left = 1'b0;
      step();
      n_checks++; if (state_dbg !== WAIT_REL) begin n_errors++; $display("FAIL click_wait_enable: got %0d want %0d", state_dbg, WAIT_REL); end
      enable = 1'b0;
      step();
      n_checks++; if (state_dbg !== IDLE) begin n_errors++; $display("FAIL click_idle: got %0d want %0d", state_dbg, IDLE); end
   endtask

   task automatic test_box_edges();
      logic [11:0] xy [8][2];
      logic        er [8];
      xy = '{'{12'd456, 12'd300}, '{12'd455, 12'd300}, '{12'd306, 12'd300}, '{12'd305, 12'd300},
             '{12'd310, 12'd293}, '{12'd310, 12'd294}, '{12'd310, 12'd351}, '{12'd310, 12'd352}};
      er = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         go_armed(10'd1);
         xpos = xy[i][0]; ypos = xy[i][1]; left = 1'b1;
         step();
         n_checks++; if (restart !== er[i]) begin n_errors++; $display("FAIL box_edge_%0d_%0d: got %b want %b", xpos, ypos, restart, er[i]); end
      end
   endtask

   task automatic test_enable_drop();
      go_armed(10'd3);
      enable = 1'b0;
      step();
      n_checks++; if (state_dbg !== IDLE || restart !== 1'b0) begin n_errors++; $display("FAIL drop_armed: got state %0d restart %b want %0d 0", state_dbg, restart, IDLE); end
      do_reset();
      enable = 1'b1; left = 1'b1;
      step();
      enable = 1'b0;
      step();
      n_checks++; if (state_dbg !== IDLE || restart !== 1'b0) begin n_errors++; $display("FAIL drop_show: got state %0d restart %b want %0d 0", state_dbg, restart, IDLE); end
   endtask

   task automatic test_best_score();
      logic [9:0] games [4];
      logic [9:0] exp;
      games = '{10'd40, 10'd25, 10'd40, 10'd60};
`ifdef END_SCREEN_BEST_SCORE_EN
      exp_q = '{10'd40, 10'd40, 10'd40, 10'd60};
`else
      exp_q = '{10'd0, 10'd0, 10'd0, 10'd0};
`endif
      do_reset();
      for (int i = 0; i < 4; i++) begin
         result_in = games[i]; enable = 1'b1; left = 1'b1;
         step();
         exp = exp_q.pop_front();
         n_checks++; if (score_out !== games[i]) begin n_errors++; $display("FAIL best_score_game%0d: got %0d want %0d", i, score_out, games[i]); end
         n_checks++; if (best_out !== exp) begin n_errors++; $display("FAIL best_game%0d: got %0d want %0d", i, best_out, exp); end
         enable = 1'b0; left = 1'b0;
         step();
      end
      rst = 1'b0;
      step();
      n_checks++; if (best_out !== 10'd0 || score_out !== 10'd0) begin n_errors++; $display("FAIL best_reset: got best %0d score %0d want 0 0", best_out, score_out); end
      rst = 1'b1;
   endtask

   task automatic test_blink();
      logic [11:0] exp;
      go_armed(10'd9);
      xpos = 12'd310; ypos = 12'd300; hcount = 11'd306; vcount = 11'd294;
      step(); step();
      n_checks++; if (rgb_out !== HI) begin n_errors++; $display("FAIL blink_corner: got %h want %h", rgb_out, HI); end
      hcount = 11'd380; vcount = 11'd320;
      step(); step();
      n_checks++; if (rgb_out !== PIX) begin n_errors++; $display("FAIL blink_interior: got %h want %h", rgb_out, PIX); end
      hcount = 11'd454;
      step(); step();
      n_checks++; if (rgb_out !== HI) begin n_errors++; $display("FAIL blink_right_edge: got %h want %h", rgb_out, HI); end
      hcount = 11'd453;
      step(); step();
      n_checks++; if (rgb_out !== PIX) begin n_errors++; $display("FAIL blink_right_inner: got %h want %h", rgb_out, PIX); end
      hcount = 11'd306; vcount = 11'd294; xpos = 12'd500;
      step(); step();
      n_checks++; if (rgb_out !== PIX) begin n_errors++; $display("FAIL blink_cursor_out: got %h want %h", rgb_out, PIX); end
      xpos = 12'd310;
      for (int i = 1; i <= 30; i++) begin
         vsync = 1'b1; step();
         vsync = 1'b0; step(); step(); step();
         exp = (((i / 15) % 2) == 0) ? HI : PIX;
         n_checks++; if (rgb_out !== exp) begin n_errors++; $display("FAIL blink_frame%0d: got %h want %h", i, rgb_out, exp); end
      end
      rst = 1'b0;
      step();
      n_checks++; if (rgb_out !== 12'h000 || state_dbg !== IDLE) begin n_errors++; $display("FAIL blink_reset: got rgb %h state %0d want 000 %0d", rgb_out, state_dbg, IDLE); end
      rst = 1'b1;
   endtask

   task automatic test_reset_mid_fire();
      go_armed(10'd2);
      xpos = 12'd310; ypos = 12'd300; left = 1'b1;
      step();
      n_checks++; if (restart !== 1'b1) begin n_errors++; $display("FAIL midfire_pre: got %b want 1", restart); end
      rst = 1'b0;
      #1;
      n_checks++; if (restart !== 1'b0) begin n_errors++; $display("FAIL midfire_suppress: got %b want 0", restart); end
      step();
      n_checks++; if (restart !== 1'b0 || state_dbg !== IDLE) begin n_errors++; $display("FAIL midfire_after: got restart %b state %0d want 0 %0d", restart, state_dbg, IDLE); end
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_pipeline();
      test_window();
      test_carried_press();
      test_click_in_box();
      test_box_edges();
      test_enable_drop();
      test_best_score();
      test_blink();
      test_reset_mid_fire();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
